store_buffer: RTL

- FIFO store buffer between the EX/MEM pipeline register and the data memory in the MEM stage.
- Accepts stores from the pipeline and drains them into the data memory one per cycle, whenever the memory port is not needed by a load.
- Loads return the youngest buffered value for a matching address (forwarding); otherwise they return memory read data.
- Owns the data-memory address, write-data and write-enable signals.

---
 rtl/store_buffer_if.sv | 47 ++++
 rtl/store_buffer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: groups the store/load request lines from EX/MEM, the
// load result lines to MEM/WB, the data-memory port and the occupancy status
// of the MEM-stage store buffer.
//   slave  : the store buffer's view
//   master : the pipeline/memory environment's view
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
);
  // pipeline store request
  logic                   st_valid;
  logic [AW-1:0]          st_addr;
  logic [DW-1:0]          st_data;
  logic                   st_ready;
  // pipeline load request and result
  logic                   ld_valid;
  logic [AW-1:0]          ld_addr;
  logic [DW-1:0]          ld_data;
  logic                   ld_stall;
  // data-memory port
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   mem_we;
  logic [DW-1:0]          mem_rdata;
  // status
  logic                   empty;
  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  st_valid, st_addr, st_data,
    input  ld_valid, ld_addr,
    input  mem_rdata,
    output st_ready, ld_data, ld_stall,
    output mem_addr, mem_wdata, mem_we,
    output empty, count
  );

  modport master (
    output st_valid, st_addr, st_data,
    output ld_valid, ld_addr,
    output mem_rdata,
    input  st_ready, ld_data, ld_stall,
    input  mem_addr, mem_wdata, mem_we,
    input  empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: FIFO store buffer between EX/MEM and the data memory.
// Stores are queued and drained one per cycle whenever the memory port is not
// taken by a load; loads get priority unless the buffer is full.
// Optional feature macro: STORE_BUF_FWD_EN
//   defined   : loads are forwarded from the youngest matching buffered store
//   undefined : a load matching any buffered store stalls and the drain takes
//               the port until no matching entry remains
// rst is asynchronous, active-low.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  sb
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // entry storage; validity is tracked separately so the payload needs no reset
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    occ;

  logic             full;
  logic             is_empty;
  logic             enq;
  logic             drain;
  logic             hit;
`ifdef STORE_BUF_FWD_EN
  logic [DW-1:0]    fwd_data;
`endif

  assign full        = (occ == FULL_CNT);
  assign is_empty    = (occ == '0);
  // registered state only: a same-cycle drain never frees a slot early
  assign enq         = sb.st_valid && !full;
  assign sb.st_ready = !full;
  assign sb.empty    = is_empty;
  assign sb.count    = occ;

  // Address match over valid entries, scanned oldest to youngest so the
  // youngest match (nearest tail) is the one that sticks.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    hit = 1'b0;
`ifdef STORE_BUF_FWD_EN
    fwd_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent_valid[idx] && (ent_addr[idx] == sb.ld_addr)) begin
        hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
        fwd_data = ent_data[idx];
`endif
      end
    end
  end

  // Port arbitration and load result.
  always_comb begin
`ifdef STORE_BUF_FWD_EN
    drain       = !is_empty && (!sb.ld_valid || full);
    sb.ld_stall = sb.ld_valid && full;
    sb.ld_data  = hit ? fwd_data : sb.mem_rdata;
`else
    // a matching load has to wait for memory to catch up, so the drain wins
    drain       = !is_empty && (!sb.ld_valid || full || hit);
    sb.ld_stall = sb.ld_valid && (full || hit);
    sb.ld_data  = sb.mem_rdata;
`endif
    if (drain) begin
      sb.mem_addr  = ent_addr[head];
      sb.mem_wdata = ent_data[head];
      sb.mem_we    = 1'b1;
    end else begin
      sb.mem_addr  = sb.ld_addr;
      sb.mem_wdata = '0;
      sb.mem_we    = 1'b0;
    end
  end

  // Pointers, occupancy and entry validity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      ent_valid <= '0;
    end else begin
      // head == tail only when empty (no drain) or full (no enqueue), so the
      // two valid-bit updates never target the same entry
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({enq, drain})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Entry payload write on enqueue.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= sb.st_addr;
      ent_data[tail] <= sb.st_data;
    end
  end

endmodule
